// File: rtl/pa_fpu_wb_arb_pkg.sv
// Shared constants for the FPU writeback arbiter.
//   - Requester index encoding used for the request/grant vectors.
//   - Default widths and starvation limit.
//   - arb_pick(): fixed-priority pick with divider starvation override.
package pa_fpu_wb_arb_pkg;

  localparam int unsigned REQ_NUM  = 4;
  localparam int unsigned IDX_EX4  = 0;
  localparam int unsigned IDX_EX3  = 1;
  localparam int unsigned IDX_EX2  = 2;
  localparam int unsigned IDX_FDSU = 3;

  localparam int unsigned DEF_DATA_WIDTH   = 64;
  localparam int unsigned DEF_DST_WIDTH    = 5;
  localparam int unsigned DEF_FFLAG_WIDTH  = 5;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned AGE_WIDTH        = 4;

  // Lowest index wins (ex4 > ex3 > ex2 > fdsu) unless the divider has aged out.
  function automatic logic [REQ_NUM-1:0] arb_pick(input logic [REQ_NUM-1:0] req,
                                                  input logic               force_fdsu);
    logic [REQ_NUM-1:0] gnt;
    gnt = '0;
    if (force_fdsu && req[IDX_FDSU]) begin
      gnt[IDX_FDSU] = 1'b1;
    end else if (req[IDX_EX4]) begin
      gnt[IDX_EX4] = 1'b1;
    end else if (req[IDX_EX3]) begin
      gnt[IDX_EX3] = 1'b1;
    end else if (req[IDX_EX2]) begin
      gnt[IDX_EX2] = 1'b1;
    end else if (req[IDX_FDSU]) begin
      gnt[IDX_FDSU] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/pa_fpu_wb_age_cnt.sv
// Saturating age counter for the divider writeback request.
//   i_clk       : clock
//   i_rst_b     : asynchronous active-low reset
//   i_req       : divider request pending
//   i_grant     : divider granted this cycle
//   o_at_limit  : counter has reached STARVE_LIMIT (divider must win next)
module pa_fpu_wb_age_cnt
  import pa_fpu_wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT  // valid range 1..15
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_req,
  input  logic i_grant,
  output logic o_at_limit
);

  localparam logic [AGE_WIDTH-1:0] LIMIT = AGE_WIDTH'(STARVE_LIMIT);

  logic [AGE_WIDTH-1:0] r_age;
  logic [AGE_WIDTH-1:0] w_age_nxt;
  logic                 w_at_limit;

  assign w_at_limit = (r_age == LIMIT);
  assign o_at_limit = w_at_limit;

  always_comb begin
    w_age_nxt = r_age;
    if (!i_req || i_grant) begin
      w_age_nxt = '0;
    end else if (!w_at_limit) begin
      w_age_nxt = r_age + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_age <= '0;
    end else begin
      r_age <= w_age_nxt;
    end
  end

endmodule

// File: rtl/pa_fpu_wb_arb.sv
// FPU result writeback arbiter: EX2/EX3/EX4 pipeline results and the
// divide/sqrt unit share one FPR write port. One requester is granted per
// cycle (combinationally) and registered into a one-entry output stage.
//   forever_cpuclk / cpurst_b        : clock, async active-low reset
//   ctrl_frbus_exN_wb_req, fdsu_*    : requests with data/dst/fflags
//   frbus_*_wb_grant                 : one-hot grants, only when the slot is free
//   rtu_fpu_wb_ready                 : downstream accepts the output stage
//   fpu_rtu_wb_*                     : registered output stage
//   frbus_xx_no_op                   : idle indication
// Optional: define PA_FPU_WB_ARB_PERF_CNT_EN to add frbus_perf_conflict_cnt,
// a saturating count of cycles with two or more requests while the slot is free.
module pa_fpu_wb_arb
  import pa_fpu_wb_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned DST_WIDTH    = DEF_DST_WIDTH,
  parameter int unsigned FFLAG_WIDTH  = DEF_FFLAG_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   ctrl_frbus_ex2_wb_req,
  input  logic                   ctrl_frbus_ex3_wb_req,
  input  logic                   ctrl_frbus_ex4_wb_req,
  input  logic                   fdsu_frbus_wb_req,
  input  logic [DATA_WIDTH-1:0]  ex2_frbus_data,
  input  logic [DATA_WIDTH-1:0]  ex3_frbus_data,
  input  logic [DATA_WIDTH-1:0]  ex4_frbus_data,
  input  logic [DATA_WIDTH-1:0]  fdsu_frbus_data,
  input  logic [DST_WIDTH-1:0]   ex2_frbus_dst,
  input  logic [DST_WIDTH-1:0]   ex3_frbus_dst,
  input  logic [DST_WIDTH-1:0]   ex4_frbus_dst,
  input  logic [DST_WIDTH-1:0]   fdsu_frbus_dst,
  input  logic [FFLAG_WIDTH-1:0] ex2_frbus_fflags,
  input  logic [FFLAG_WIDTH-1:0] ex3_frbus_fflags,
  input  logic [FFLAG_WIDTH-1:0] ex4_frbus_fflags,
  input  logic [FFLAG_WIDTH-1:0] fdsu_frbus_fflags,
  output logic                   frbus_ctrl_ex2_wb_grant,
  output logic                   frbus_ctrl_ex3_wb_grant,
  output logic                   frbus_ctrl_ex4_wb_grant,
  output logic                   frbus_fdsu_wb_grant,
  input  logic                   rtu_fpu_wb_ready,
  output logic                   fpu_rtu_wb_vld,
  output logic [DATA_WIDTH-1:0]  fpu_rtu_wb_data,
  output logic [DST_WIDTH-1:0]   fpu_rtu_wb_dst,
  output logic [FFLAG_WIDTH-1:0] fpu_rtu_wb_fflags,
  output logic                   frbus_xx_no_op
`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
  ,
  output logic [15:0]            frbus_perf_conflict_cnt
`endif
);

  logic [REQ_NUM-1:0]     w_req;
  logic [REQ_NUM-1:0]     w_grant;
  logic                   w_slot_free;
  logic                   w_any_grant;
  logic                   w_fdsu_aged;
  logic [DATA_WIDTH-1:0]  w_nxt_data;
  logic [DST_WIDTH-1:0]   w_nxt_dst;
  logic [FFLAG_WIDTH-1:0] w_nxt_fflags;

  logic                   r_vld;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [DST_WIDTH-1:0]   r_dst;
  logic [FFLAG_WIDTH-1:0] r_fflags;

  assign w_req[IDX_EX4]  = ctrl_frbus_ex4_wb_req;
  assign w_req[IDX_EX3]  = ctrl_frbus_ex3_wb_req;
  assign w_req[IDX_EX2]  = ctrl_frbus_ex2_wb_req;
  assign w_req[IDX_FDSU] = fdsu_frbus_wb_req;

  // The slot is free when empty or being drained this cycle, which allows
  // a new result to load behind the one leaving (1 result per cycle).
  assign w_slot_free = !r_vld || rtu_fpu_wb_ready;
  assign w_grant     = w_slot_free ? arb_pick(w_req, w_fdsu_aged) : '0;
  assign w_any_grant = |w_grant;

  assign frbus_ctrl_ex4_wb_grant = w_grant[IDX_EX4];
  assign frbus_ctrl_ex3_wb_grant = w_grant[IDX_EX3];
  assign frbus_ctrl_ex2_wb_grant = w_grant[IDX_EX2];
  assign frbus_fdsu_wb_grant     = w_grant[IDX_FDSU];

  pa_fpu_wb_age_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_age_cnt (
    .i_clk      (forever_cpuclk),
    .i_rst_b    (cpurst_b),
    .i_req      (fdsu_frbus_wb_req),
    .i_grant    (w_grant[IDX_FDSU]),
    .o_at_limit (w_fdsu_aged)
  );

  always_comb begin
    w_nxt_data   = '0;
    w_nxt_dst    = '0;
    w_nxt_fflags = '0;
    unique case (1'b1)
      w_grant[IDX_EX4]: begin
        w_nxt_data   = ex4_frbus_data;
        w_nxt_dst    = ex4_frbus_dst;
        w_nxt_fflags = ex4_frbus_fflags;
      end
      w_grant[IDX_EX3]: begin
        w_nxt_data   = ex3_frbus_data;
        w_nxt_dst    = ex3_frbus_dst;
        w_nxt_fflags = ex3_frbus_fflags;
      end
      w_grant[IDX_EX2]: begin
        w_nxt_data   = ex2_frbus_data;
        w_nxt_dst    = ex2_frbus_dst;
        w_nxt_fflags = ex2_frbus_fflags;
      end
      w_grant[IDX_FDSU]: begin
        w_nxt_data   = fdsu_frbus_data;
        w_nxt_dst    = fdsu_frbus_dst;
        w_nxt_fflags = fdsu_frbus_fflags;
      end
      default: begin
        w_nxt_data   = '0;
        w_nxt_dst    = '0;
        w_nxt_fflags = '0;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_vld    <= 1'b0;
      r_data   <= '0;
      r_dst    <= '0;
      r_fflags <= '0;
    end else if (w_any_grant) begin
      r_vld    <= 1'b1;
      r_data   <= w_nxt_data;
      r_dst    <= w_nxt_dst;
      r_fflags <= w_nxt_fflags;
    end else if (rtu_fpu_wb_ready) begin
      r_vld    <= 1'b0;
    end
  end

  assign fpu_rtu_wb_vld    = r_vld;
  assign fpu_rtu_wb_data   = r_data;
  assign fpu_rtu_wb_dst    = r_dst;
  assign fpu_rtu_wb_fflags = r_fflags;
  assign frbus_xx_no_op    = !r_vld && !(|w_req);

`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
  logic [15:0] r_conflict_cnt;
  logic        w_conflict;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_conflict = w_slot_free && ((w_req & (w_req - 1'b1)) != '0);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign frbus_perf_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_pa_fpu_wb_arb.sv
module tb_pa_fpu_wb_arb;

  localparam int LIM = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  dst;
    logic [4:0]  fflags;
  } pl_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        ex2_req, ex3_req, ex4_req, fdsu_req;
  logic [63:0] ex2_data, ex3_data, ex4_data, fdsu_data;
  logic [4:0]  ex2_dst, ex3_dst, ex4_dst, fdsu_dst;
  logic [4:0]  ex2_ff, ex3_ff, ex4_ff, fdsu_ff;
  logic        g_ex2, g_ex3, g_ex4, g_fdsu;
  logic        ready;
  logic        wb_vld;
  logic [63:0] wb_data;
  logic [4:0]  wb_dst, wb_ff;
  logic        no_op;
`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
  logic [15:0] perf_cnt;
  int          perf_exp;
`endif

  pa_fpu_wb_arb dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_b),
    .ctrl_frbus_ex2_wb_req   (ex2_req),
    .ctrl_frbus_ex3_wb_req   (ex3_req),
    .ctrl_frbus_ex4_wb_req   (ex4_req),
    .fdsu_frbus_wb_req       (fdsu_req),
    .ex2_frbus_data          (ex2_data),
    .ex3_frbus_data          (ex3_data),
    .ex4_frbus_data          (ex4_data),
    .fdsu_frbus_data         (fdsu_data),
    .ex2_frbus_dst           (ex2_dst),
    .ex3_frbus_dst           (ex3_dst),
    .ex4_frbus_dst           (ex4_dst),
    .fdsu_frbus_dst          (fdsu_dst),
    .ex2_frbus_fflags        (ex2_ff),
    .ex3_frbus_fflags        (ex3_ff),
    .ex4_frbus_fflags        (ex4_ff),
    .fdsu_frbus_fflags       (fdsu_ff),
    .frbus_ctrl_ex2_wb_grant (g_ex2),
    .frbus_ctrl_ex3_wb_grant (g_ex3),
    .frbus_ctrl_ex4_wb_grant (g_ex4),
    .frbus_fdsu_wb_grant     (g_fdsu),
    .rtu_fpu_wb_ready        (ready),
    .fpu_rtu_wb_vld          (wb_vld),
    .fpu_rtu_wb_data         (wb_data),
    .fpu_rtu_wb_dst          (wb_dst),
    .fpu_rtu_wb_fflags       (wb_ff),
    .frbus_xx_no_op          (no_op)
`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
    ,
    .frbus_perf_conflict_cnt (perf_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Requester model: index 0=ex4, 1=ex3, 2=ex2, 3=fdsu.
  logic [3:0] pend    = '0;
  logic [3:0] granted = '0;
  pl_t        pl[4];
  pl_t        sb[$];          // results granted but not yet accepted downstream
  int         fdsu_wait = 0;  // cycles the divider has waited, capped at LIM
  bit         in_reset  = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply();
    ex4_req  = pend[0]; ex4_data  = pl[0].data; ex4_dst  = pl[0].dst; ex4_ff  = pl[0].fflags;
    ex3_req  = pend[1]; ex3_data  = pl[1].data; ex3_dst  = pl[1].dst; ex3_ff  = pl[1].fflags;
    ex2_req  = pend[2]; ex2_data  = pl[2].data; ex2_dst  = pl[2].dst; ex2_ff  = pl[2].fflags;
    fdsu_req = pend[3]; fdsu_data = pl[3].data; fdsu_dst = pl[3].dst; fdsu_ff = pl[3].fflags;
  endtask

  // Called just after a rising edge: retire granted requests, raise new ones
  // in mask (only where none is pending), then advance one cycle.
  task automatic cycle(input logic [3:0] mask, input logic rdy);
    pend    = pend & ~granted;
    granted = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && !pend[i]) begin
        pend[i]        = 1'b1;
        pl[i].data     = {$urandom, $urandom};
        pl[i].dst      = 5'($urandom);
        pl[i].fflags   = 5'($urandom);
      end
    end
    ready = rdy;
    apply();
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard: expected grant from priority rules, expected output
  // from the queue of granted-but-unaccepted results.
  always @(negedge clk) begin
    logic [3:0] exp_g;
    bit         mv;
    bit         slot;
    bit         found;
    if (!in_reset) begin
      mv    = (sb.size() > 0);
      slot  = !mv || (ready === 1'b1);
      exp_g = '0;
      found = 1'b0;
      if (slot) begin
        if (pend[3] && fdsu_wait >= LIM) begin
          exp_g[3] = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (pend[i] && !found) begin
              exp_g[i] = 1'b1;
              found    = 1'b1;
            end
          end
        end
      end
      check("grant", {124'd0, g_fdsu, g_ex2, g_ex3, g_ex4}, {124'd0, exp_g});
      check("wb_vld", {127'd0, wb_vld}, {127'd0, mv});
      if (mv) check("wb_payload", {54'd0, wb_data, wb_dst, wb_ff}, {54'd0, sb[0]});
      check("no_op", {127'd0, no_op}, {127'd0, (!mv && pend == 4'd0)});
`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
      check("perf_cnt", {112'd0, perf_cnt}, 128'(perf_exp));
      if (slot && $countones(pend) >= 2 && perf_exp < 65535) perf_exp++;
`endif
      if (mv && ready) void'(sb.pop_front());
      for (int i = 0; i < 4; i++) if (exp_g[i]) sb.push_back(pl[i]);
      granted = exp_g;
      if (pend[3] && !exp_g[3]) fdsu_wait = (fdsu_wait < LIM) ? fdsu_wait + 1 : LIM;
      else fdsu_wait = 0;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_vld"},   {127'd0, wb_vld}, 128'd0);
    check({tag, "_data"},  {54'd0, wb_data, wb_dst, wb_ff}, 128'd0);
    check({tag, "_grant"}, {124'd0, g_fdsu, g_ex2, g_ex3, g_ex4}, 128'd0);
    check({tag, "_no_op"}, {127'd0, no_op}, 128'd1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pl[i] = '0;
    ready = 1'b0;
    apply();
`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
    perf_exp = 0;
`endif
    #12;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_b    = 1'b1;
    in_reset = 1'b0;

    // Single ex3 result with a known payload.
    pend[1]      = 1'b1;
    pl[1].data   = 64'h3FF0_0000_0000_0000;
    pl[1].dst    = 5'd7;
    pl[1].fflags = 5'd0;
    cycle(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

    // All pipeline stages at once: ex4, ex3, ex2 back to back.
    cycle(4'b0111, 1'b1);
    for (int k = 0; k < 4; k++) cycle(4'b0000, 1'b1);

    // Back-pressure: output held while ex4 waits, then released.
    cycle(4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

    // Divider held against continuous ex4 traffic.
    cycle(4'b1001, 1'b1);
    for (int k = 0; k < 7; k++) cycle(4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

    // Divider and ex2 together.
    cycle(4'b1100, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(4'($urandom & $urandom), ($urandom_range(0, 3) != 0));
    end

    // Reset while the output stage holds a result.
    cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    check("pre_reset_vld", {127'd0, wb_vld}, 128'd1);
    in_reset = 1'b1;
    #2;
    rst_b   = 1'b0;
    pend    = '0;
    granted = '0;
    apply();
    sb.delete();
    fdsu_wait = 0;
`ifdef PA_FPU_WB_ARB_PERF_CNT_EN
    perf_exp = 0;
`endif
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    rst_b    = 1'b1;
    in_reset = 1'b0;

    for (int k = 0; k < 500; k++) begin
      cycle(4'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int k = 0; k < 10; k++) cycle(4'b0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pa_fpu_wb_arb.md
Name: pa_fpu_wb_arb

Overview:
- Single-port FPU result writeback arbiter.
- Four requesters share the FPR write port: the EX2, EX3 and EX4 pipeline writeback requests, plus the iterative divide/sqrt unit result.
- Grants one requester per cycle and registers the winner into a one-entry output stage toward the register file/RTU.
- Contains an age counter so the divider cannot be starved by back-to-back pipeline traffic.

Parameters:
DATA_WIDTH, 64, FPR write data width
DST_WIDTH, 5, destination register index width
FFLAG_WIDTH, 5, exception flag width
STARVE_LIMIT, 4, cycles fdsu may wait before it is forced to top priority (range 1..15)

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  async active-low reset
ctrl_frbus_ex2_wb_req  in  1  EX2 writeback request
ctrl_frbus_ex3_wb_req  in  1  EX3 writeback request
ctrl_frbus_ex4_wb_req  in  1  EX4 writeback request
fdsu_frbus_wb_req  in  1  divider result request; held until granted
exN_frbus_data / fdsu_frbus_data  in  DATA_WIDTH each  result data, N=2,3,4
exN_frbus_dst / fdsu_frbus_dst  in  DST_WIDTH each  destination index
exN_frbus_fflags / fdsu_frbus_fflags  in  FFLAG_WIDTH each  flags
frbus_ctrl_ex2_wb_grant  out  1  EX2 grant
frbus_ctrl_ex3_wb_grant  out  1  EX3 grant
frbus_ctrl_ex4_wb_grant  out  1  EX4 grant
frbus_fdsu_wb_grant  out  1  divider grant
rtu_fpu_wb_ready  in  1  downstream accepts output this cycle
fpu_rtu_wb_vld  out  1  output stage valid
fpu_rtu_wb_data  out  DATA_WIDTH  registered data
fpu_rtu_wb_dst  out  DST_WIDTH  registered destination
fpu_rtu_wb_fflags  out  FFLAG_WIDTH  registered flags
frbus_xx_no_op  out  1  no request pending and output stage empty

Behaviour:
- Reset: fpu_rtu_wb_vld=0; data/dst/fflags=0; age counter=0; all grants=0 (combinational from the 0-valued state); frbus_xx_no_op=1.
- Slot free: slot_free = !fpu_rtu_wb_vld || rtu_fpu_wb_ready.
- Grants are combinational, one-hot or zero, and only asserted when slot_free.
- Normal priority: ex4 > ex3 > ex2 > fdsu. Pipeline order keeps older results first.
- Starvation override: if fdsu_frbus_wb_req && age==STARVE_LIMIT, fdsu wins over all pipeline requests.
- Age counter (4 bits):
  - Increments each cycle fdsu_frbus_wb_req=1 and fdsu is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on fdsu grant or when fdsu_frbus_wb_req=0.
- Output stage:
  - On any grant, load the winner's data/dst/fflags and set vld=1 at the next edge. Latency from request to wb_vld is 1 cycle.
  - If vld && ready && no grant, clear vld.
  - If vld && !ready, hold all outputs stable with no grants.
- Simultaneous drain and grant in the same cycle: new data loads and vld stays 1, giving back-to-back throughput of 1 per cycle.
- Requesters hold req, data, dst and fflags stable until granted. The arbiter does not check this.
- Reset mid-operation: asynchronously clears vld and the counter. Any pending output is lost; upstream is reset together.
- frbus_xx_no_op = !fpu_rtu_wb_vld && no req input asserted.

Optional Feature:
- Macro PA_FPU_WB_ARB_PERF_CNT_EN.
- Defined:
  - Adds output frbus_perf_conflict_cnt [15:0].
  - Counter is saturating and reset to 0.
  - Increments each cycle in which at least two requests are asserted while slot_free. Does not wrap at 16'hFFFF.
- Undefined: port and logic absent; arbitration behaviour identical.

Decomposition:
- Shared constants file: requester index encoding (EX4=0, EX3=1, EX2=2, FDSU=3) and width defaults.
- One sub-module pa_fpu_wb_age_cnt (saturating age counter with clear/inc/limit compare). Everything else flat.

Test Plan:
- Reset, then ex3 req with data=64'h3FF0_0000_0000_0000, dst=7, ready=1 -> ex3 grant same cycle; next cycle wb_vld=1, dst=7, data matches; following cycle vld=0.
- ex2, ex3 and ex4 requests together, ready=1 -> grants ex4, then ex3, then ex2 on consecutive cycles; wb_vld stays high 3 cycles.
- Output valid with ready=0 for 3 cycles while ex4 requests -> no grants, outputs stable; ready=1 -> ex4 granted that cycle and loaded next edge.
- fdsu req held while ex4 requests continuously, STARVE_LIMIT=4 -> ex4 granted 4 cycles, fdsu granted on cycle 5, age returns to 0.
- Assert cpurst_b low while wb_vld=1 -> vld=0 immediately (asynchronous), no_op=1, no grants.
- With PA_FPU_WB_ARB_PERF_CNT_EN, ex2 and fdsu requesting together for 2 cycles with slot free -> counter=2; preload near max -> holds 16'hFFFF.
